// File: rtl/csr_pkg.sv
// Shared CSR addresses, mstatus field positions and the fixed misa value for csr_regfile.
package csr_pkg;

    typedef logic [11:0] csr_addr_t;

    localparam csr_addr_t CSR_MSTATUS   = 12'h300;
    localparam csr_addr_t CSR_MISA      = 12'h301;
    localparam csr_addr_t CSR_MTVEC     = 12'h305;
    localparam csr_addr_t CSR_MSCRATCH  = 12'h340;
    localparam csr_addr_t CSR_MEPC      = 12'h341;
    localparam csr_addr_t CSR_MCAUSE    = 12'h342;
    localparam csr_addr_t CSR_MHARTID   = 12'hF14;
    localparam csr_addr_t CSR_MCYCLE    = 12'hB00;
    localparam csr_addr_t CSR_MINSTRET  = 12'hB02;
    localparam csr_addr_t CSR_MCYCLEH   = 12'hB80;
    localparam csr_addr_t CSR_MINSTRETH = 12'hB82;
    localparam csr_addr_t CSR_CYCLE     = 12'hC00;
    localparam csr_addr_t CSR_INSTRET   = 12'hC02;
    localparam csr_addr_t CSR_CYCLEH    = 12'hC80;
    localparam csr_addr_t CSR_INSTRETH  = 12'hC82;

    localparam int MSTATUS_MIE  = 3;
    localparam int MSTATUS_MPIE = 7;

    localparam logic [31:0] MISA_VALUE = 32'h4000_0100;

    // The top two address bits equal to 2'b11 mark the read-only CSR space.
    function automatic logic is_ro_space(csr_addr_t addr);
        return addr[11:10] == 2'b11;
    endfunction

endpackage

// File: rtl/csr_counter64.sv
// 64-bit free-running counter with independent 32-bit half writes; used for mcycle/minstret
// when CSR_COUNTERS_EN is defined.
module csr_counter64 (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        inc_i,
    input  logic        lo_we_i,
    input  logic        hi_we_i,
    input  logic [31:0] wdata_i,
    output logic [63:0] value_o
);

    // A half write replaces that half only: no increment and no carry into the other half.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            value_o <= '0;
        end else if (lo_we_i) begin
            value_o[31:0] <= wdata_i;
        end else if (hi_we_i) begin
            value_o[63:32] <= wdata_i;
        end else if (inc_i) begin
            value_o <= value_o + 64'd1;
        end
    end

endmodule

// File: rtl/csr_regfile.sv
// Machine-mode CSR file: combinational read, write-back commit, trap/mret state and counters.
// Define CSR_COUNTERS_EN to build mcycle/minstret and their read-only user aliases.
module csr_regfile
    import csr_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int HART_ID = 0
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic [11:0]      csr_raddr_i,
    output logic [WIDTH-1:0] csr_rdata_o,
    output logic             csr_illegal_o,
    input  logic             csr_re_write_i,
    input  logic             csr_we_i,
    input  logic [11:0]      csr_waddr_i,
    input  logic [WIDTH-1:0] csr_wdata_i,
    input  logic             retire_i,
    input  logic             trap_i,
    input  logic [WIDTH-1:0] trap_pc_i,
    input  logic [WIDTH-1:0] trap_cause_i,
    input  logic             mret_i,
    output logic [WIDTH-1:0] trap_vector_o,
    output logic [WIDTH-1:0] mepc_o,
    output logic             mie_o
);

    logic             mie;
    logic             mpie;
    logic [WIDTH-1:2] mtvec;
    logic [WIDTH-1:0] mscratch;
    logic [WIDTH-1:0] mepc;
    logic [WIDTH-1:0] mcause;
    logic             implemented;

    logic wr_mstatus, wr_mtvec, wr_mscratch, wr_mepc, wr_mcause;

    assign wr_mstatus  = csr_we_i && (csr_waddr_i == CSR_MSTATUS);
    assign wr_mtvec    = csr_we_i && (csr_waddr_i == CSR_MTVEC);
    assign wr_mscratch = csr_we_i && (csr_waddr_i == CSR_MSCRATCH);
    assign wr_mepc     = csr_we_i && (csr_waddr_i == CSR_MEPC);
    assign wr_mcause   = csr_we_i && (csr_waddr_i == CSR_MCAUSE);

`ifdef CSR_COUNTERS_EN
    logic [63:0] mcycle;
    logic [63:0] minstret;

    csr_counter64 u_mcycle (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .inc_i   (1'b1),
        .lo_we_i (csr_we_i && (csr_waddr_i == CSR_MCYCLE)),
        .hi_we_i (csr_we_i && (csr_waddr_i == CSR_MCYCLEH)),
        .wdata_i (csr_wdata_i[31:0]),
        .value_o (mcycle)
    );

    csr_counter64 u_minstret (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .inc_i   (retire_i),
        .lo_we_i (csr_we_i && (csr_waddr_i == CSR_MINSTRET)),
        .hi_we_i (csr_we_i && (csr_waddr_i == CSR_MINSTRETH)),
        .wdata_i (csr_wdata_i[31:0]),
        .value_o (minstret)
    );
`else
    logic unused_retire;
    assign unused_retire = retire_i;
`endif

    // Trap owns mepc/mcause/mstatus; mret owns mstatus; a software write only lands where neither acts.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            mie      <= 1'b0;
            mpie     <= 1'b0;
            mtvec    <= '0;
            mscratch <= '0;
            mepc     <= '0;
            mcause   <= '0;
        end else begin
            if (wr_mtvec)    mtvec    <= csr_wdata_i[WIDTH-1:2];
            if (wr_mscratch) mscratch <= csr_wdata_i;
            if (trap_i) begin
                mepc   <= trap_pc_i & ~WIDTH'(1);
                mcause <= trap_cause_i;
                mpie   <= mie;
                mie    <= 1'b0;
            end else begin
                if (mret_i) begin
                    mie  <= mpie;
                    mpie <= 1'b1;
                end else if (wr_mstatus) begin
                    mie  <= csr_wdata_i[MSTATUS_MIE];
                    mpie <= csr_wdata_i[MSTATUS_MPIE];
                end
                if (wr_mepc)   mepc   <= csr_wdata_i & ~WIDTH'(1);
                if (wr_mcause) mcause <= csr_wdata_i;
            end
        end
    end

    // NOTE: every output of this always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        csr_rdata_o = '0;
        implemented = 1'b1;
        case (csr_raddr_i)
            CSR_MSTATUS: begin
                csr_rdata_o[MSTATUS_MIE]  = mie;
                csr_rdata_o[MSTATUS_MPIE] = mpie;
            end
            CSR_MISA:     csr_rdata_o = WIDTH'(MISA_VALUE);
            CSR_MTVEC:    csr_rdata_o = {mtvec, 2'b00};
            CSR_MSCRATCH: csr_rdata_o = mscratch;
            CSR_MEPC:     csr_rdata_o = mepc;
            CSR_MCAUSE:   csr_rdata_o = mcause;
            CSR_MHARTID:  csr_rdata_o = WIDTH'(HART_ID);
`ifdef CSR_COUNTERS_EN
            CSR_MCYCLE,    CSR_CYCLE:    csr_rdata_o = WIDTH'(mcycle[31:0]);
            CSR_MCYCLEH,   CSR_CYCLEH:   csr_rdata_o = WIDTH'(mcycle[63:32]);
            CSR_MINSTRET,  CSR_INSTRET:  csr_rdata_o = WIDTH'(minstret[31:0]);
            CSR_MINSTRETH, CSR_INSTRETH: csr_rdata_o = WIDTH'(minstret[63:32]);
`endif
            default:      implemented = 1'b0;
        endcase
    end

    assign csr_illegal_o = !implemented || (csr_re_write_i && is_ro_space(csr_raddr_i));
    assign trap_vector_o = {mtvec, 2'b00};
    assign mepc_o        = mepc;
    assign mie_o         = mie;

endmodule

// File: tb/tb_csr_regfile.sv
// Directed self-checking bench for csr_regfile; counter checks follow CSR_COUNTERS_EN.
module tb_csr_regfile;

    localparam int WIDTH   = 32;
    localparam int HART_ID = 3;

    logic             clk_i = 1'b0;
    logic             rst_n_i;
    logic [11:0]      csr_raddr_i;
    logic [WIDTH-1:0] csr_rdata_o;
    logic             csr_illegal_o;
    logic             csr_re_write_i;
    logic             csr_we_i;
    logic [11:0]      csr_waddr_i;
    logic [WIDTH-1:0] csr_wdata_i;
    logic             retire_i;
    logic             trap_i;
    logic [WIDTH-1:0] trap_pc_i;
    logic [WIDTH-1:0] trap_cause_i;
    logic             mret_i;
    logic [WIDTH-1:0] trap_vector_o;
    logic [WIDTH-1:0] mepc_o;
    logic             mie_o;

    int pass_cnt  = 0;
    int total_cnt = 0;

    csr_regfile #(.WIDTH(WIDTH), .HART_ID(HART_ID)) dut (
        .clk_i          (clk_i),
        .rst_n_i        (rst_n_i),
        .csr_raddr_i    (csr_raddr_i),
        .csr_rdata_o    (csr_rdata_o),
        .csr_illegal_o  (csr_illegal_o),
        .csr_re_write_i (csr_re_write_i),
        .csr_we_i       (csr_we_i),
        .csr_waddr_i    (csr_waddr_i),
        .csr_wdata_i    (csr_wdata_i),
        .retire_i       (retire_i),
        .trap_i         (trap_i),
        .trap_pc_i      (trap_pc_i),
        .trap_cause_i   (trap_cause_i),
        .mret_i         (mret_i),
        .trap_vector_o  (trap_vector_o),
        .mepc_o         (mepc_o),
        .mie_o          (mie_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic rd(input logic [11:0] addr);
        csr_raddr_i    = addr;
        csr_re_write_i = 1'b0;
        #1;
    endtask

    task automatic wr(input logic [11:0] addr, input logic [WIDTH-1:0] data);
        csr_we_i    = 1'b1;
        csr_waddr_i = addr;
        csr_wdata_i = data;
        tick();
        csr_we_i    = 1'b0;
    endtask

    task automatic test_reset();
        rst_n_i = 1'b0;
        tick();
        tick();
        rst_n_i = 1'b1;
        rd(12'h300); total_cnt++;
        if (csr_rdata_o !== 32'h0) $display("FAIL reset_mstatus: got %h want %h", csr_rdata_o, 32'h0); else pass_cnt++;
        total_cnt++;
        if (csr_illegal_o !== 1'b0) $display("FAIL reset_illegal: got %b want 0", csr_illegal_o); else pass_cnt++;
        rd(12'h305); total_cnt++;
        if (csr_rdata_o !== 32'h0) $display("FAIL reset_mtvec: got %h want %h", csr_rdata_o, 32'h0); else pass_cnt++;
        rd(12'h341); total_cnt++;
        if (csr_rdata_o !== 32'h0) $display("FAIL reset_mepc: got %h want %h", csr_rdata_o, 32'h0); else pass_cnt++;
        rd(12'h342); total_cnt++;
        if (csr_rdata_o !== 32'h0) $display("FAIL reset_mcause: got %h want %h", csr_rdata_o, 32'h0); else pass_cnt++;
        rd(12'h301); total_cnt++;
        if (csr_rdata_o !== 32'h4000_0100) $display("FAIL reset_misa: got %h want %h", csr_rdata_o, 32'h4000_0100); else pass_cnt++;
        rd(12'hF14); total_cnt++;
        if (csr_rdata_o !== 32'd3) $display("FAIL reset_mhartid: got %h want %h", csr_rdata_o, 32'd3); else pass_cnt++;
        total_cnt++;
        if (csr_illegal_o !== 1'b0) $display("FAIL reset_mhartid_illegal: got %b want 0", csr_illegal_o); else pass_cnt++;
    endtask

    task automatic test_mtvec();
        rd(12'h305);
        csr_we_i    = 1'b1;
        csr_waddr_i = 12'h305;
        csr_wdata_i = 32'h8000_0007;
        #1; total_cnt++;
        if (csr_rdata_o !== 32'h0) $display("FAIL mtvec_same_cycle: got %h want %h", csr_rdata_o, 32'h0); else pass_cnt++;
        tick();
        csr_we_i = 1'b0;
        #1; total_cnt++;
        if (csr_rdata_o !== 32'h8000_0004) $display("FAIL mtvec_read: got %h want %h", csr_rdata_o, 32'h8000_0004); else pass_cnt++;
        total_cnt++;
        if (trap_vector_o !== 32'h8000_0004) $display("FAIL trap_vector: got %h want %h", trap_vector_o, 32'h8000_0004); else pass_cnt++;
        wr(12'h300, 32'hFFFF_FFFF);
        rd(12'h300); total_cnt++;
        if (csr_rdata_o !== 32'h88) $display("FAIL mstatus_mask: got %h want %h", csr_rdata_o, 32'h88); else pass_cnt++;
        wr(12'h341, 32'h0000_0103);
        rd(12'h341); total_cnt++;
        if (csr_rdata_o !== 32'h102) $display("FAIL mepc_bit0: got %h want %h", csr_rdata_o, 32'h102); else pass_cnt++;
        wr(12'h342, 32'hDEAD_BEEF);
        rd(12'h342); total_cnt++;
        if (csr_rdata_o !== 32'hDEAD_BEEF) $display("FAIL mcause_rw: got %h want %h", csr_rdata_o, 32'hDEAD_BEEF); else pass_cnt++;
    endtask

    task automatic test_trap_mret();
        wr(12'h300, 32'h8);
        trap_i       = 1'b1;
        trap_pc_i    = 32'h1235;
        trap_cause_i = 32'hB;
        tick();
        trap_i = 1'b0;
        total_cnt++;
        if (mepc_o !== 32'h1234) $display("FAIL trap_mepc: got %h want %h", mepc_o, 32'h1234); else pass_cnt++;
        rd(12'h342); total_cnt++;
        if (csr_rdata_o !== 32'hB) $display("FAIL trap_mcause: got %h want %h", csr_rdata_o, 32'hB); else pass_cnt++;
        rd(12'h300); total_cnt++;
        if (csr_rdata_o !== 32'h80) $display("FAIL trap_mstatus: got %h want %h", csr_rdata_o, 32'h80); else pass_cnt++;
        total_cnt++;
        if (mie_o !== 1'b0) $display("FAIL trap_mie: got %b want 0", mie_o); else pass_cnt++;
        mret_i = 1'b1;
        tick();
        mret_i = 1'b0;
        rd(12'h300); total_cnt++;
        if (csr_rdata_o !== 32'h88) $display("FAIL mret_mstatus: got %h want %h", csr_rdata_o, 32'h88); else pass_cnt++;
        total_cnt++;
        if (mie_o !== 1'b1) $display("FAIL mret_mie: got %b want 1", mie_o); else pass_cnt++;
    endtask

    task automatic test_priority();
        wr(12'h300, 32'h0);
        wr(12'h300, 32'h8);
        // Trap + mstatus write: trap result (MPIE=1, MIE=0) must win.
        trap_i = 1'b1; trap_pc_i = 32'h2000; trap_cause_i = 32'h3;
        csr_we_i = 1'b1; csr_waddr_i = 12'h300; csr_wdata_i = 32'h8;
        tick();
        trap_i = 1'b0; csr_we_i = 1'b0;
        rd(12'h300); total_cnt++;
        if (csr_rdata_o !== 32'h80) $display("FAIL trap_vs_mstatus: got %h want %h", csr_rdata_o, 32'h80); else pass_cnt++;
        // Trap + mscratch write: both commit.
        trap_i = 1'b1; trap_pc_i = 32'h3001; trap_cause_i = 32'h7;
        csr_we_i = 1'b1; csr_waddr_i = 12'h340; csr_wdata_i = 32'hA5;
        tick();
        trap_i = 1'b0; csr_we_i = 1'b0;
        rd(12'h340); total_cnt++;
        if (csr_rdata_o !== 32'hA5) $display("FAIL trap_plus_mscratch: got %h want %h", csr_rdata_o, 32'hA5); else pass_cnt++;
        total_cnt++;
        if (mepc_o !== 32'h3000) $display("FAIL trap_plus_mscratch_mepc: got %h want %h", mepc_o, 32'h3000); else pass_cnt++;
        // Trap + mepc write: trap PC wins.
        trap_i = 1'b1; trap_pc_i = 32'h7777; trap_cause_i = 32'h2;
        csr_we_i = 1'b1; csr_waddr_i = 12'h341; csr_wdata_i = 32'h5554;
        tick();
        trap_i = 1'b0; csr_we_i = 1'b0;
        total_cnt++;
        if (mepc_o !== 32'h7776) $display("FAIL trap_vs_mepc: got %h want %h", mepc_o, 32'h7776); else pass_cnt++;
        // State now MIE=0, MPIE=0; mret + mstatus write: mret wins (MIE=0, MPIE=1).
        mret_i = 1'b1;
        csr_we_i = 1'b1; csr_waddr_i = 12'h300; csr_wdata_i = 32'h8;
        tick();
        mret_i = 1'b0; csr_we_i = 1'b0;
        rd(12'h300); total_cnt++;
        if (csr_rdata_o !== 32'h80) $display("FAIL mret_vs_mstatus: got %h want %h", csr_rdata_o, 32'h80); else pass_cnt++;
    endtask

    task automatic test_counters();
`ifdef CSR_COUNTERS_EN
        wr(12'hB00, 32'hFFFF_FFFF);
        rd(12'hB00); total_cnt++;
        if (csr_rdata_o !== 32'hFFFF_FFFF) $display("FAIL mcycle_write: got %h want %h", csr_rdata_o, 32'hFFFF_FFFF); else pass_cnt++;
        rd(12'hC80); total_cnt++;
        if (csr_rdata_o !== 32'h0) $display("FAIL mcycleh_hold: got %h want %h", csr_rdata_o, 32'h0); else pass_cnt++;
        tick();
        rd(12'hB80); total_cnt++;
        if (csr_rdata_o !== 32'h1) $display("FAIL mcycleh_carry: got %h want %h", csr_rdata_o, 32'h1); else pass_cnt++;
        rd(12'hC00); total_cnt++;
        if (csr_rdata_o !== 32'h0) $display("FAIL mcycle_carry_lo: got %h want %h", csr_rdata_o, 32'h0); else pass_cnt++;
        // Full 64-bit wrap.
        wr(12'hB80, 32'hFFFF_FFFF);
        wr(12'hB00, 32'hFFFF_FFFF);
        rd(12'hB80); total_cnt++;
        if (csr_rdata_o !== 32'hFFFF_FFFF) $display("FAIL mcycleh_preset: got %h want %h", csr_rdata_o, 32'hFFFF_FFFF); else pass_cnt++;
        tick();
        rd(12'hB00); total_cnt++;
        if (csr_rdata_o !== 32'h0) $display("FAIL mcycle_wrap_lo: got %h want %h", csr_rdata_o, 32'h0); else pass_cnt++;
        rd(12'hB80); total_cnt++;
        if (csr_rdata_o !== 32'h0) $display("FAIL mcycle_wrap_hi: got %h want %h", csr_rdata_o, 32'h0); else pass_cnt++;
        wr(12'hB02, 32'h10);
        retire_i = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        retire_i = 1'b0;
        rd(12'hB02); total_cnt++;
        if (csr_rdata_o !== 32'h15) $display("FAIL minstret_count: got %h want %h", csr_rdata_o, 32'h15); else pass_cnt++;
        rd(12'hC02); total_cnt++;
        if (csr_rdata_o !== 32'h15) $display("FAIL instret_alias: got %h want %h", csr_rdata_o, 32'h15); else pass_cnt++;
        csr_re_write_i = 1'b1;
        #1; total_cnt++;
        if (csr_illegal_o !== 1'b1) $display("FAIL instret_write_illegal: got %b want 1", csr_illegal_o); else pass_cnt++;
        csr_re_write_i = 1'b0;
`else
        rd(12'hB00); total_cnt++;
        if (csr_illegal_o !== 1'b1) $display("FAIL no_counter_illegal: got %b want 1", csr_illegal_o); else pass_cnt++;
        total_cnt++;
        if (csr_rdata_o !== 32'h0) $display("FAIL no_counter_rdata: got %h want %h", csr_rdata_o, 32'h0); else pass_cnt++;
        rd(12'hC00); total_cnt++;
        if (csr_illegal_o !== 1'b1) $display("FAIL no_cycle_illegal: got %b want 1", csr_illegal_o); else pass_cnt++;
`endif
    endtask

    task automatic test_illegal();
        csr_raddr_i    = 12'hF14;
        csr_re_write_i = 1'b1;
        #1; total_cnt++;
        if (csr_illegal_o !== 1'b1) $display("FAIL mhartid_write_illegal: got %b want 1", csr_illegal_o); else pass_cnt++;
        wr(12'hF14, 32'h55);
        csr_re_write_i = 1'b0;
        #1; total_cnt++;
        if (csr_rdata_o !== 32'd3) $display("FAIL mhartid_unchanged: got %h want %h", csr_rdata_o, 32'd3); else pass_cnt++;
        wr(12'h301, 32'h0);
        rd(12'h301); total_cnt++;
        if (csr_rdata_o !== 32'h4000_0100) $display("FAIL misa_unchanged: got %h want %h", csr_rdata_o, 32'h4000_0100); else pass_cnt++;
        rd(12'h7C0); total_cnt++;
        if (csr_illegal_o !== 1'b1) $display("FAIL unimpl_illegal: got %b want 1", csr_illegal_o); else pass_cnt++;
        total_cnt++;
        if (csr_rdata_o !== 32'h0) $display("FAIL unimpl_rdata: got %h want %h", csr_rdata_o, 32'h0); else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        wr(12'h340, 32'h1234_5678);
        rst_n_i = 1'b0;
        trap_i = 1'b1; trap_pc_i = 32'h4444; trap_cause_i = 32'h9;
        csr_we_i = 1'b1; csr_waddr_i = 12'h340; csr_wdata_i = 32'hCAFE;
        tick();
        rst_n_i = 1'b1; trap_i = 1'b0; csr_we_i = 1'b0;
        rd(12'h340); total_cnt++;
        if (csr_rdata_o !== 32'h0) $display("FAIL rst_mscratch: got %h want %h", csr_rdata_o, 32'h0); else pass_cnt++;
        total_cnt++;
        if (mepc_o !== 32'h0) $display("FAIL rst_mepc: got %h want %h", mepc_o, 32'h0); else pass_cnt++;
        total_cnt++;
        if (trap_vector_o !== 32'h0) $display("FAIL rst_trap_vector: got %h want %h", trap_vector_o, 32'h0); else pass_cnt++;
        rd(12'h300); total_cnt++;
        if (csr_rdata_o !== 32'h0) $display("FAIL rst_mstatus: got %h want %h", csr_rdata_o, 32'h0); else pass_cnt++;
`ifdef CSR_COUNTERS_EN
        rd(12'hB00); total_cnt++;
        if (csr_rdata_o !== 32'h0) $display("FAIL rst_mcycle: got %h want %h", csr_rdata_o, 32'h0); else pass_cnt++;
        rd(12'hB02); total_cnt++;
        if (csr_rdata_o !== 32'h0) $display("FAIL rst_minstret: got %h want %h", csr_rdata_o, 32'h0); else pass_cnt++;
`endif
    endtask

    initial begin
        rst_n_i        = 1'b0;
        csr_raddr_i    = '0;
        csr_re_write_i = 1'b0;
        csr_we_i       = 1'b0;
        csr_waddr_i    = '0;
        csr_wdata_i    = '0;
        retire_i       = 1'b0;
        trap_i         = 1'b0;
        trap_pc_i      = '0;
        trap_cause_i   = '0;
        mret_i         = 1'b0;
        test_reset();
        test_mtvec();
        test_trap_mret();
        test_priority();
        test_counters();
        test_illegal();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
